tx_gearbox: RTL
===============

TX_GEARBOX -- requirements
Module: tx_gearbox

Interface
REQ-001 SHALL have the port i_txc, input, 1 bit: the single clock; every register uses its rising edge.
REQ-002 SHALL have the port i_reset, input, 1 bit: reset, asynchronous and active-high.
REQ-003 SHALL have the port i_init_done, input, 1 bit: the PCS is initialised; while it is low the gearbox idles.
REQ-004 SHALL have the port i_txd, input, 64 bits: the encoded 64b/66b block payload; byte 0 is in bits [7:0]; it is transmitted lsb first.
REQ-005 SHALL have the port i_tx_header, input, 2 bits: the sync header of the block; bit 0 is transmitted first.
REQ-006 SHALL have the port o_tx_pause, output, 1 bit: registered; when high, upstream holds its state for that cycle.
REQ-007 SHALL have the port o_txd, output, 32 bits: the registered serializer word; bit 0 is transmitted first.
REQ-008 SHALL have the port o_sequence, output, 6 bits: present only under TX_GEARBOX_SEQ_OUT_EN.

Function
REQ-009 SHALL hold a sequence counter seq, 6 bits, that counts 0..32 and wraps from 32 to 0; it advances by one per cycle while i_init_done is high.
REQ-010 SHALL drive o_tx_pause high exactly when seq == 32, and low otherwise.
REQ-011 SHALL sample {i_txd, i_tx_header} on cycles where seq < 32 and seq[0] == 0 (block cycle A); it SHALL ignore the inputs on all other cycles.
REQ-012 SHALL append 66 bits on cycle A, header first: {i_txd, i_tx_header}, with the header in the lowest bits, placed at the bit position given by the current fill.
REQ-013 SHALL pop the lowest 32 buffer bits into o_txd on every running cycle, including cycle A (after the append), cycle B and the pause cycle, and SHALL shift the remainder down.
REQ-014 SHALL update the fill counter each running cycle as fill + 66 - 32 on cycle A and as fill - 32 on cycle B and the pause cycle.
REQ-015 The fill counter SHALL be 0 at seq 0 and 30 at seq 30 (maximum 96 after an append); the buffer SHALL be 96 bits wide.
REQ-016 The fill counter SHALL be 32 at seq 32 and SHALL return to 0 after the pause cycle.
REQ-017 SHALL have a latency of 1 cycle: the bits sampled on cycle A SHALL first appear in o_txd in the following cycle, and o_txd[1:0] SHALL equal the header of the first block after start.
REQ-018 SHALL raise the sticky internal flag err_ovf on an overflow (fill > 96) or an underflow (a pop with fill < 32); this is unreachable under REQ-009 to REQ-016 and exists for assertions only.
REQ-019 SHALL, on a fall of i_init_done mid-frame, clear seq and the fill counter to 0 and drive o_txd and o_tx_pause to 0 on the next edge.
REQ-020 SHALL, on a rise of i_init_done, start at seq 0 with an empty buffer.
REQ-021 SHALL ignore the input data during the pause cycle even if it changes.

Reset
REQ-022 SHALL, while i_reset is high, drive seq, the fill counter, the buffer, o_txd, o_tx_pause, o_sequence and err_ovf to 0 asynchronously.
REQ-023 SHALL, on release of i_reset, have its first active edge with i_init_done high be seq 0 (cycle A).

Configuration
REQ-024 SHALL, when TX_GEARBOX_SEQ_OUT_EN is defined, expose o_sequence equal to the registered seq, for GT external-sequence mode.
REQ-025 SHALL, when TX_GEARBOX_SEQ_OUT_EN is undefined, omit the port; all other behaviour SHALL be identical.

Structure
REQ-026 SHALL put GB_SEQ_MAX=32, GB_BUF_W=96, GB_BLOCK_W=66 and GB_WORD_W=32 in the shared package gearbox_pkg; the SYNC_DATA and SYNC_CTL constants SHALL come from encoder_pkg.
REQ-027 SHALL be a single module with no sub-module; the buffer shift/insert SHALL be a local function.

Verification
REQ-028 Reset release and start: hold i_init_done=1; on every cycle A present header 2'b01 and data 64'h0 -> o_txd at the first post-reset cycle is 32'h1; o_tx_pause pulses high once per 33 cycles, at seq 32.
REQ-029 Bit accuracy: feed 16 blocks with i_txd = 64'h0123456789ABCDEF + n and header 2'b10 -> the concatenated 33 o_txd words equal the 1056-bit lsb-first packing of the 16 blocks, with no gaps.
REQ-030 Pause hold: during seq 32, drive i_txd=64'hDEAD and header 2'b11 -> the values are not absorbed; the next word after the pause is the header of block 0 of the new frame.
REQ-031 Mid-frame init drop: drop i_init_done at seq 17 -> the next edge shows o_txd=0 and o_tx_pause=0; on re-raise the output restarts at seq 0, with the first word's bits [1:0] equal to the new header.
REQ-032 Async reset: assert i_reset at seq 25 between clock edges -> all outputs are 0 immediately; err_ovf stays 0 throughout a soak of 10,000 cycles.

Source files
------------

// File: rtl/encoder_pkg.sv
// 64b/66b sync header encodings shared by the PCS encoder and gearbox.
// Bit 0 of each header is the first bit on the line.
package encoder_pkg;

  localparam logic [1:0] SYNC_DATA = 2'b10;
  localparam logic [1:0] SYNC_CTL  = 2'b01;

endpackage

// File: rtl/gearbox_pkg.sv
// Shared gearbox sizing constants and the 33-cycle frame classification.
package gearbox_pkg;

  localparam int GB_SEQ_MAX = 32;
  localparam int GB_BUF_W   = 96;
  localparam int GB_BLOCK_W = 66;
  localparam int GB_WORD_W  = 32;

  localparam int GB_SEQ_W  = 6;
  // Fill arithmetic is one bit wider than the buffer range to expose overflow.
  localparam int GB_FILL_W = 8;

  localparam logic [GB_SEQ_W-1:0] GB_SEQ_LAST = GB_SEQ_W'(GB_SEQ_MAX);

  typedef enum logic [1:0] {
    CYC_A,
    CYC_B,
    CYC_PAUSE
  } gb_cyc_e;

  function automatic gb_cyc_e gb_cycle(input logic [GB_SEQ_W-1:0] seq);
    if (seq == GB_SEQ_LAST) return CYC_PAUSE;
    if (!seq[0])            return CYC_A;
    return CYC_B;
  endfunction

endpackage

// File: rtl/tx_gearbox.sv
// 66-to-32 bit TX gearbox: packs 64b/66b blocks into a 32-bit serializer word stream,
// pausing upstream one cycle in 33. Define TX_GEARBOX_SEQ_OUT_EN to expose o_sequence.
module tx_gearbox
  import gearbox_pkg::*;
(
  input  logic        i_txc,
  input  logic        i_reset,
  input  logic        i_init_done,
  input  logic [63:0] i_txd,
  input  logic [1:0]  i_tx_header,
`ifdef TX_GEARBOX_SEQ_OUT_EN
  output logic [5:0]  o_sequence,
`endif
  output logic        o_tx_pause,
  output logic [31:0] o_txd
);

  localparam logic [GB_FILL_W-1:0] FILL_BLOCK = GB_FILL_W'(GB_BLOCK_W);
  localparam logic [GB_FILL_W-1:0] FILL_WORD  = GB_FILL_W'(GB_WORD_W);
  localparam logic [GB_FILL_W-1:0] FILL_MAX   = GB_FILL_W'(GB_BUF_W);

  logic [GB_SEQ_W-1:0]  seq;
  logic [GB_SEQ_W-1:0]  seq_nxt;
  logic [GB_FILL_W-1:0] fill;
  logic [GB_FILL_W-1:0] fill_app;
  logic [GB_BUF_W-1:0]  gb_buf;
  logic [GB_BUF_W-1:0]  merged;
  logic                 ovf;
  logic                 err_ovf;
  gb_cyc_e              cyc;

  function automatic logic [GB_BUF_W-1:0] buf_insert(
    input logic [GB_BUF_W-1:0]   b,
    input logic [GB_BLOCK_W-1:0] blk,
    input logic [GB_FILL_W-1:0]  at
  );
    return b | ({{(GB_BUF_W-GB_BLOCK_W){1'b0}}, blk} << at);
  endfunction

  always_comb begin
    cyc      = gb_cycle(seq);
    merged   = gb_buf;
    fill_app = fill;
    if (cyc == CYC_A) begin
      merged   = buf_insert(gb_buf, {i_txd, i_tx_header}, fill);
      fill_app = fill + FILL_BLOCK;
    end
    ovf     = (fill_app > FILL_MAX) || (fill_app < FILL_WORD);
    seq_nxt = (cyc == CYC_PAUSE) ? '0 : seq + GB_SEQ_W'(1);
  end

  always_ff @(posedge i_txc or posedge i_reset) begin
    if (i_reset) begin
      seq        <= '0;
      fill       <= '0;
      gb_buf     <= '0;
      o_txd      <= '0;
      o_tx_pause <= 1'b0;
      err_ovf    <= 1'b0;
    end else if (!i_init_done) begin
      seq        <= '0;
      fill       <= '0;
      gb_buf     <= '0;
      o_txd      <= '0;
      o_tx_pause <= 1'b0;
    end else begin
      seq        <= seq_nxt;
      fill       <= fill_app - FILL_WORD;
      gb_buf     <= merged >> GB_WORD_W;
      o_txd      <= merged[GB_WORD_W-1:0];
      o_tx_pause <= (seq_nxt == GB_SEQ_LAST);
      err_ovf    <= err_ovf | ovf;
    end
  end

`ifdef TX_GEARBOX_SEQ_OUT_EN
  assign o_sequence = seq;
`endif

  // Unreachable with correct fill accounting; flags buffer sizing faults.
  err_ovf_never: assert property (@(posedge i_txc) disable iff (i_reset) !err_ovf);

endmodule
